// File: rtl/fc_popcount_argmax_if.sv
// Level-handshake bus between the pooled feature-map producer and the FC argmax stage.
// master = upstream/driver side, slave = fc_popcount_argmax side.
interface fc_popcount_argmax_if #(
    parameter int IC          = 8,
    parameter int IMG_SIZE    = 14,
    parameter int NUM_CLASSES = 10
);
    localparam int N  = IC * IMG_SIZE * IMG_SIZE;
    localparam int SW = $clog2(N + 1);
    localparam int IW = $clog2(NUM_CLASSES);

    logic                           data_in_ready;
    logic [IMG_SIZE*IMG_SIZE-1:0]   img_in [0:IC-1];
    logic [N-1:0]                   weights [0:NUM_CLASSES-1];
    logic [IW-1:0]                  class_idx;
    logic [SW-1:0]                  best_score;
    logic                           class_valid;
    logic                           data_out_ready;

    modport master (
        output data_in_ready, img_in, weights,
        input  class_idx, best_score, class_valid, data_out_ready
    );

    modport slave (
        input  data_in_ready, img_in, weights,
        output class_idx, best_score, class_valid, data_out_ready
    );
endinterface

// File: rtl/fc_popcount_argmax.sv
// Binary FC classifier: XNOR-popcount score per class, CHUNK bits per cycle, then argmax.
// Optional macro FC_REJECT_EN: class_valid reports whether the winning score reaches REJECT_THRESHOLD.
module fc_popcount_argmax #(
    parameter int IC               = 8,
    parameter int IMG_SIZE         = 14,
    parameter int NUM_CLASSES      = 10,
    parameter int CHUNK            = 64,
    parameter int REJECT_THRESHOLD = 784
) (
    input  logic                   clk,
    input  logic                   rst,
    fc_popcount_argmax_if.slave    bus
);
    localparam int PIX  = IMG_SIZE * IMG_SIZE;
    localparam int N    = IC * PIX;
    localparam int NCH  = (N + CHUNK - 1) / CHUNK;
    localparam int SW   = $clog2(N + 1);
    localparam int IW   = $clog2(NUM_CLASSES);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = $clog2(CHUNK + 1);
    localparam int PADW = NCH * CHUNK;

    localparam logic [PADW-1:0] VALID_BITS = PADW'({N{1'b1}});

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   cls, cls_n;
    logic [CHW-1:0]  chunk, chunk_n;
    logic [SW-1:0]   acc, acc_n;
    logic [SW-1:0]   run_best, run_best_n;
    logic [IW-1:0]   run_idx, run_idx_n;
    logic [IW-1:0]   class_idx_q, class_idx_n;
    logic [SW-1:0]   best_score_q, best_score_n;
    logic            class_valid_q, class_valid_n;

    logic [N-1:0]     x_flat;
    logic [PADW-1:0]  x_pad, w_pad;
    logic [CHUNK-1:0] x_sl, w_sl, m_sl, hits;
    logic [PW-1:0]    pc;
    logic             better;

    always_comb begin
        x_flat = '0;
        for (int unsigned c = 0; c < IC; c++) begin
            x_flat[c*PIX +: PIX] = bus.img_in[c];
        end
    end

    // Pad bits are zero in both operands, so their XNOR is 1; the mask keeps them out of the score.
    always_comb begin
        x_pad = PADW'(x_flat);
        w_pad = PADW'(bus.weights[cls]);
        x_sl  = x_pad[chunk*CHUNK +: CHUNK];
        w_sl  = w_pad[chunk*CHUNK +: CHUNK];
        m_sl  = VALID_BITS[chunk*CHUNK +: CHUNK];
        hits  = ~(x_sl ^ w_sl) & m_sl;
        pc    = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            pc = pc + PW'(hits[i]);
        end
    end

    assign better = (cls == '0) || (acc > run_best);

    always_comb begin
        state_n       = state;
        cls_n         = cls;
        chunk_n       = chunk;
        acc_n         = acc;
        run_best_n    = run_best;
        run_idx_n     = run_idx;
        class_idx_n   = class_idx_q;
        best_score_n  = best_score_q;
        class_valid_n = class_valid_q;

        case (state)
            IDLE: begin
                if (bus.data_in_ready) begin
                    state_n    = ACCUM;
                    cls_n      = '0;
                    chunk_n    = '0;
                    acc_n      = '0;
                    run_best_n = '0;
                    run_idx_n  = '0;
                end
            end
            ACCUM: begin
                if (!bus.data_in_ready) begin
                    state_n = IDLE;
                end else begin
                    acc_n = acc + SW'(pc);
                    if (chunk == CHW'(NCH - 1)) begin
                        state_n = COMPARE;
                    end else begin
                        chunk_n = chunk + CHW'(1);
                    end
                end
            end
            COMPARE: begin
                if (!bus.data_in_ready) begin
                    state_n = IDLE;
                end else begin
                    if (better) begin
                        run_best_n = acc;
                        run_idx_n  = cls;
                    end
                    if (cls == IW'(NUM_CLASSES - 1)) begin
                        // Result registers load from the post-compare values on the same edge.
                        state_n      = DONE;
                        class_idx_n  = run_idx_n;
                        best_score_n = run_best_n;
`ifdef FC_REJECT_EN
                        class_valid_n = (run_best_n >= SW'(REJECT_THRESHOLD));
`else
                        class_valid_n = 1'b1;
`endif
                    end else begin
                        state_n = ACCUM;
                        cls_n   = cls + IW'(1);
                        chunk_n = '0;
                        acc_n   = '0;
                    end
                end
            end
            DONE: begin
                if (!bus.data_in_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cls           <= '0;
            chunk         <= '0;
            acc           <= '0;
            run_best      <= '0;
            run_idx       <= '0;
            class_idx_q   <= '0;
            best_score_q  <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state         <= state_n;
            cls           <= cls_n;
            chunk         <= chunk_n;
            acc           <= acc_n;
            run_best      <= run_best_n;
            run_idx       <= run_idx_n;
            class_idx_q   <= class_idx_n;
            best_score_q  <= best_score_n;
            class_valid_q <= class_valid_n;
        end
    end

    assign bus.class_idx      = class_idx_q;
    assign bus.best_score     = best_score_q;
    assign bus.class_valid    = class_valid_q;
    assign bus.data_out_ready = (state == DONE);
endmodule

// File: tb/tb_fc_popcount_argmax.sv
// Directed + randomized bench for fc_popcount_argmax against a bit-matching score model.
module tb_fc_popcount_argmax;
    localparam int IC               = 8;
    localparam int IMG_SIZE         = 14;
    localparam int NUM_CLASSES      = 10;
    localparam int CHUNK            = 64;
    localparam int REJECT_THRESHOLD = 784;
    localparam int PIX              = IMG_SIZE * IMG_SIZE;
    localparam int N                = IC * PIX;
    localparam int LAT              = 260;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_popcount_argmax_if #(.IC(IC), .IMG_SIZE(IMG_SIZE), .NUM_CLASSES(NUM_CLASSES)) bus ();

    fc_popcount_argmax #(
        .IC(IC), .IMG_SIZE(IMG_SIZE), .NUM_CLASSES(NUM_CLASSES),
        .CHUNK(CHUNK), .REJECT_THRESHOLD(REJECT_THRESHOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;

    bit [PIX-1:0] img_m [IC];
    bit [N-1:0]   w_m   [NUM_CLASSES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply();
        for (int c = 0; c < IC; c++) bus.img_in[c] = img_m[c];
        for (int k = 0; k < NUM_CLASSES; k++) bus.weights[k] = w_m[k];
    endtask

    task automatic set_img(input bit v);
        for (int c = 0; c < IC; c++) img_m[c] = v ? '1 : '0;
    endtask

    task automatic set_w(input int k, input bit v);
        w_m[k] = v ? '1 : '0;
    endtask

    // Score = number of real positions where image bit equals weight bit.
    task automatic model(output int idx, output int best, output bit valid);
        int s;
        idx  = 0;
        best = -1;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            s = 0;
            for (int c = 0; c < IC; c++)
                for (int p = 0; p < PIX; p++)
                    if (img_m[c][p] == w_m[k][c*PIX + p]) s++;
            if (s > best) begin
                best = s;
                idx  = k;
            end
        end
`ifdef FC_REJECT_EN
        valid = (best >= REJECT_THRESHOLD);
`else
        valid = 1'b1;
`endif
    endtask

    // Called just after a negedge; the following posedge is the sampling edge 0.
    task automatic run_check(input string tag);
        int e_idx, e_best, lat;
        bit e_valid;
        model(e_idx, e_best, e_valid);
        apply();
        bus.data_in_ready = 1'b1;
        lat = -1;
        for (int k = 0; k <= LAT + 40; k++) begin
            @(posedge clk); #1;
            if (bus.data_out_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_idx"}, bus.class_idx, e_idx);
        check({tag, "_score"}, bus.best_score, e_best);
        check({tag, "_valid"}, bus.class_valid, e_valid);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_hold_ready"}, bus.data_out_ready, 1);
        check({tag, "_hold_idx"}, bus.class_idx, e_idx);
        @(negedge clk);
        bus.data_in_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_clear"}, bus.data_out_ready, 0);
        check({tag, "_idx_after"}, bus.class_idx, e_idx);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.data_in_ready = 1'b0;
        set_img(1'b0);
        for (int k = 0; k < NUM_CLASSES; k++) set_w(k, 1'b0);
        apply();
        repeat (3) @(negedge clk);
        check("rst_ready", bus.data_out_ready, 0);
        check("rst_idx",   bus.class_idx, 0);
        check("rst_score", bus.best_score, 0);
        check("rst_valid", bus.class_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic argmax: only class 3 matches everywhere.
        set_img(1'b1);
        for (int k = 0; k < NUM_CLASSES; k++) set_w(k, 1'b0);
        set_w(3, 1'b1);
        run_check("basic");

        // Asynchronous reset mid-accumulation, between edges.
        apply();
        bus.data_in_ready = 1'b1;
        repeat (51) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.data_in_ready = 1'b0;
        #1;
        check("async_rst_ready", bus.data_out_ready, 0);
        check("async_rst_idx",   bus.class_idx, 0);
        check("async_rst_score", bus.best_score, 0);
        check("async_rst_valid", bus.class_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_check("after_rst");

        // Abort mid-run: previous result (class 3) must be held.
        set_w(3, 1'b0);
        set_w(6, 1'b1);
        apply();
        bus.data_in_ready = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        bus.data_in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("abort_ready", bus.data_out_ready, 0);
            check("abort_idx", bus.class_idx, 3);
        end
        @(negedge clk);
        run_check("reraise");

        // Tie between classes 2 and 7; pad bits must not add to the score.
        set_img(1'b0);
        for (int k = 0; k < NUM_CLASSES; k++) set_w(k, 1'b1);
        set_w(2, 1'b0);
        set_w(7, 1'b0);
        run_check("tie");

        // Class 5 matches on exactly 700 bits, others on none.
        set_img(1'b1);
        for (int k = 0; k < NUM_CLASSES; k++) set_w(k, 1'b0);
        for (int i = 0; i < 700; i++) w_m[5][i] = 1'b1;
        run_check("reject");

        // Randomized back-to-back runs with a one-cycle gap.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < IC; c++)
                for (int p = 0; p < PIX; p++) img_m[c][p] = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_CLASSES; k++)
                for (int i = 0; i < N; i++) w_m[k][i] = 1'($urandom_range(0, 1));
            run_check($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
